speicher_arbiter: RTL and testbench

Shares the processor's single memory port between instruction fetch and data load/store. It sits between the `Steuerung` control FSM and the memory, and turns the fetch/load/store request levels into registered memory strobes. It returns the `BefehlGeladen`, `DatenGeladen` and `DatenGespeichert` completion pulses that the control FSM waits on. Memory latency is variable and ends when the memory raises `SpeicherBereit`.

---
 rtl/hans_pkg.sv | 28 ++
 rtl/speicher_arbiter.sv | 176 +++++++++++++++++
 tb/tb_speicher_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hans_pkg.sv
// hans_pkg
// Shared definitions for the memory-side blocks of the processor.
// Holds the default bus widths and the one-hot state codes of the
// memory port arbiter, plus an enum type built on those codes so the
// state register shows readable names in simulation.

package hans_pkg;

  // Default bus widths.
  localparam int ADRESS_BREITE = 32;
  localparam int DATEN_BREITE  = 32;

  // One-hot state codes of the memory arbiter.
  localparam logic [4:0] IDLE      = 5'b00001;
  localparam logic [4:0] BEFEHL    = 5'b00010;
  localparam logic [4:0] LADEN     = 5'b00100;
  localparam logic [4:0] SPEICHERN = 5'b01000;
  localparam logic [4:0] QUITT     = 5'b10000;

  typedef enum logic [4:0] {
    ZUSTAND_IDLE      = IDLE,
    ZUSTAND_BEFEHL    = BEFEHL,
    ZUSTAND_LADEN     = LADEN,
    ZUSTAND_SPEICHERN = SPEICHERN,
    ZUSTAND_QUITT     = QUITT
  } zustandT;

endpackage

// File: rtl/speicher_arbiter.sv
// speicher_arbiter
// Shares the single memory port between instruction fetch and data
// load/store. Request levels from the control FSM are sampled only in
// IDLE (store > load > fetch), turned into registered memory strobes,
// held until the memory signals SpeicherBereit, and answered with a
// one-cycle completion pulse from the QUITT state. Every output is a
// register; nothing passes combinationally from an input to an output.
//
// Ports:
//   Clock, Reset                 clock, synchronous active-high reset
//   BefehlAnfrage, BefehlAdresse fetch request level and PC
//   BefehlDaten, BefehlGeladen   last fetched word, fetch-done pulse
//   LadeAnfrage, SpeicherAnfrage load / store request levels
//   DatenAdresse, SchreibDaten   load/store address, store data
//   LeseDaten, DatenGeladen      last loaded word, load-done pulse
//   DatenGespeichert             store-done pulse
//   SpeicherAdresse, SpeicherSchreibDaten, SpeicherLesen,
//   SpeicherSchreiben            registered memory bus
//   SpeicherLeseDaten, SpeicherBereit  memory read data, access done

module speicher_arbiter
  import hans_pkg::*;
#(
  parameter int ADRESS_BREITE = hans_pkg::ADRESS_BREITE,
  parameter int DATEN_BREITE  = hans_pkg::DATEN_BREITE
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     BefehlAnfrage,
  input  logic [ADRESS_BREITE-1:0] BefehlAdresse,
  output logic [DATEN_BREITE-1:0]  BefehlDaten,
  output logic                     BefehlGeladen,
  input  logic                     LadeAnfrage,
  input  logic                     SpeicherAnfrage,
  input  logic [ADRESS_BREITE-1:0] DatenAdresse,
  input  logic [DATEN_BREITE-1:0]  SchreibDaten,
  output logic [DATEN_BREITE-1:0]  LeseDaten,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [DATEN_BREITE-1:0]  SpeicherSchreibDaten,
  output logic                     SpeicherLesen,
  output logic                     SpeicherSchreiben,
  input  logic [DATEN_BREITE-1:0]  SpeicherLeseDaten,
  input  logic                     SpeicherBereit
);

  zustandT                  zustand;
  zustandT                  zustandNaechst;
  logic [ADRESS_BREITE-1:0] adresseNaechst;
  logic [DATEN_BREITE-1:0]  schreibDatenNaechst;
  logic                     lesenNaechst;
  logic                     schreibenNaechst;
  logic [DATEN_BREITE-1:0]  befehlDatenNaechst;
  logic [DATEN_BREITE-1:0]  leseDatenNaechst;
  logic                     befehlGeladenNaechst;
  logic                     datenGeladenNaechst;
  logic                     datenGespeichertNaechst;

  // Next-state and next-output logic. Every register holds its value by
  // default, so address, write data and strobe stay frozen throughout a
  // wait-stated access; the completion pulses default to 0 so they last
  // exactly one cycle (the QUITT cycle).
  always_comb begin
    zustandNaechst          = zustand;
    adresseNaechst          = SpeicherAdresse;
    schreibDatenNaechst     = SpeicherSchreibDaten;
    lesenNaechst            = SpeicherLesen;
    schreibenNaechst        = SpeicherSchreiben;
    befehlDatenNaechst      = BefehlDaten;
    leseDatenNaechst        = LeseDaten;
    befehlGeladenNaechst    = 1'b0;
    datenGeladenNaechst     = 1'b0;
    datenGespeichertNaechst = 1'b0;

    case (zustand)
      ZUSTAND_IDLE: begin
        lesenNaechst     = 1'b0;
        schreibenNaechst = 1'b0;
        // Store beats load so an illegal load+store upstream still
        // resolves deterministically; fetch has the lowest priority.
        if (SpeicherAnfrage) begin
          zustandNaechst      = ZUSTAND_SPEICHERN;
          adresseNaechst      = DatenAdresse;
          schreibDatenNaechst = SchreibDaten;
          schreibenNaechst    = 1'b1;
        end else if (LadeAnfrage) begin
          zustandNaechst = ZUSTAND_LADEN;
          adresseNaechst = DatenAdresse;
          lesenNaechst   = 1'b1;
        end else if (BefehlAnfrage) begin
          zustandNaechst = ZUSTAND_BEFEHL;
          adresseNaechst = BefehlAdresse;
          lesenNaechst   = 1'b1;
        end
      end

      ZUSTAND_BEFEHL: begin
        if (SpeicherBereit) begin
          zustandNaechst       = ZUSTAND_QUITT;
          lesenNaechst         = 1'b0;
          befehlDatenNaechst   = SpeicherLeseDaten;
          befehlGeladenNaechst = 1'b1;
        end
      end

      ZUSTAND_LADEN: begin
        if (SpeicherBereit) begin
          zustandNaechst      = ZUSTAND_QUITT;
          lesenNaechst        = 1'b0;
          leseDatenNaechst    = SpeicherLeseDaten;
          datenGeladenNaechst = 1'b1;
        end
      end

      ZUSTAND_SPEICHERN: begin
        if (SpeicherBereit) begin
          zustandNaechst          = ZUSTAND_QUITT;
          schreibenNaechst        = 1'b0;
          datenGespeichertNaechst = 1'b1;
        end
      end

      // One dead cycle so the requester can drop its level before the
      // next arbitration in IDLE; requests and SpeicherBereit are ignored.
      ZUSTAND_QUITT: begin
        zustandNaechst = ZUSTAND_IDLE;
      end

      default: begin
        zustandNaechst   = ZUSTAND_IDLE;
        lesenNaechst     = 1'b0;
        schreibenNaechst = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset clears everything, including the
  // data and address registers, and drops an in-flight strobe without
  // producing a completion pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand              <= ZUSTAND_IDLE;
      SpeicherAdresse      <= '0;
      SpeicherSchreibDaten <= '0;
      SpeicherLesen        <= 1'b0;
      SpeicherSchreiben    <= 1'b0;
      BefehlDaten          <= '0;
      LeseDaten            <= '0;
      BefehlGeladen        <= 1'b0;
      DatenGeladen         <= 1'b0;
      DatenGespeichert     <= 1'b0;
    end else begin
      zustand              <= zustandNaechst;
      SpeicherAdresse      <= adresseNaechst;
      SpeicherSchreibDaten <= schreibDatenNaechst;
      SpeicherLesen        <= lesenNaechst;
      SpeicherSchreiben    <= schreibenNaechst;
      BefehlDaten          <= befehlDatenNaechst;
      LeseDaten            <= leseDatenNaechst;
      BefehlGeladen        <= befehlGeladenNaechst;
      DatenGeladen         <= datenGeladenNaechst;
      DatenGespeichert     <= datenGespeichertNaechst;
    end
  end

  // Structural invariants: a valid one-hot state, never both strobes,
  // never more than one completion pulse.
  assert property (@(posedge Clock) disable iff (Reset)
    $onehot(zustand));
  assert property (@(posedge Clock) disable iff (Reset)
    $onehot0({SpeicherLesen, SpeicherSchreiben}));
  assert property (@(posedge Clock) disable iff (Reset)
    $onehot0({BefehlGeladen, DatenGeladen, DatenGespeichert}));

endmodule

// File: tb/tb_speicher_arbiter.sv
// tb_speicher_arbiter
// Scoreboard bench for speicher_arbiter. Stimulus pushes the expected
// memory accesses (in priority order, with their expected grant cycle)
// into a queue; a negedge monitor acting as the memory pops them when a
// strobe appears, answers after a random latency and pushes the expected
// completion pulse, which the same monitor checks in the following cycle.

module tb_speicher_arbiter;

  localparam int K_FETCH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        BefehlAnfrage = 1'b0;
  logic [31:0] BefehlAdresse = '0;
  logic [31:0] BefehlDaten;
  logic        BefehlGeladen;
  logic        LadeAnfrage = 1'b0;
  logic        SpeicherAnfrage = 1'b0;
  logic [31:0] DatenAdresse = '0;
  logic [31:0] SchreibDaten = '0;
  logic [31:0] LeseDaten;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic [31:0] SpeicherAdresse;
  logic [31:0] SpeicherSchreibDaten;
  logic        SpeicherLesen;
  logic        SpeicherSchreiben;
  logic [31:0] SpeicherLeseDaten = '0;
  logic        SpeicherBereit = 1'b0;

  always #5 Clock = ~Clock;

  speicher_arbiter dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .BefehlAnfrage       (BefehlAnfrage),
    .BefehlAdresse       (BefehlAdresse),
    .BefehlDaten         (BefehlDaten),
    .BefehlGeladen       (BefehlGeladen),
    .LadeAnfrage         (LadeAnfrage),
    .SpeicherAnfrage     (SpeicherAnfrage),
    .DatenAdresse        (DatenAdresse),
    .SchreibDaten        (SchreibDaten),
    .LeseDaten           (LeseDaten),
    .DatenGeladen        (DatenGeladen),
    .DatenGespeichert    (DatenGespeichert),
    .SpeicherAdresse     (SpeicherAdresse),
    .SpeicherSchreibDaten(SpeicherSchreibDaten),
    .SpeicherLesen       (SpeicherLesen),
    .SpeicherSchreiben   (SpeicherSchreiben),
    .SpeicherLeseDaten   (SpeicherLeseDaten),
    .SpeicherBereit      (SpeicherBereit)
  );

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
    bit          chained;
  } accessT;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          due;
  } completionT;

  accessT      accQ[$];
  completionT  compQ[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  bit          resetSampled = 1'b0;
  int          forceLatency = -1;
  bit          useForceData = 1'b0;
  logic [31:0] forceData = '0;
  int          holdCount = 0;
  bit          memBusy = 1'b0;
  bit          expectLow = 1'b0;
  int          waitCnt = 0;
  int          latency = 0;
  accessT      cur;
  logic [31:0] rdData = '0;
  logic [31:0] befehlModel = '0;
  logic [31:0] leseModel = '0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h (cycle %0d)",
               name, act, exp, cycle);
    end
  endtask

  function automatic logic [1:0] expStrobe(input int kind);
    return (kind == K_STORE) ? 2'b10 : 2'b01;
  endfunction

  task automatic finishRun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Cycle counter and reset sampling, taken at the active edge.
  always @(posedge Clock) begin
    cycle++;
    resetSampled = Reset;
  end

  // Monitor, memory model and requester reaction, all on the falling edge.
  always @(negedge Clock) begin
    logic [31:0] expPulse;
    logic [1:0]  strobeVec;
    completionT  c;
    accessT      e;
    if (resetSampled) begin
      checkOutput("reset ctrl",
                  32'({SpeicherLesen, SpeicherSchreiben, BefehlGeladen,
                       DatenGeladen, DatenGespeichert}), 32'h0);
      checkOutput("reset SpeicherAdresse", SpeicherAdresse, 32'h0);
      checkOutput("reset SpeicherSchreibDaten", SpeicherSchreibDaten, 32'h0);
      checkOutput("reset BefehlDaten", BefehlDaten, 32'h0);
      checkOutput("reset LeseDaten", LeseDaten, 32'h0);
      befehlModel    = '0;
      leseModel      = '0;
      accQ.delete();
      compQ.delete();
      memBusy        = 1'b0;
      expectLow      = 1'b0;
      SpeicherBereit = 1'b0;
    end else begin
      expPulse = '0;
      if (compQ.size() > 0 && compQ[0].due <= cycle) begin
        c = compQ.pop_front();
        expPulse = 32'(1) << c.kind;
        if (c.kind == K_FETCH) befehlModel = c.data;
        if (c.kind == K_LOAD)  leseModel = c.data;
        if (accQ.size() > 0 && accQ[0].chained) begin
          accQ[0].due     = cycle + 2;
          accQ[0].chained = 1'b0;
        end
        if (c.kind == K_STORE) SpeicherAnfrage = 1'b0;
        if (c.kind == K_LOAD)  LadeAnfrage = 1'b0;
        if (c.kind == K_FETCH) begin
          if (holdCount > 0) holdCount--;
          else BefehlAnfrage = 1'b0;
        end
      end
      checkOutput("pulses",
                  32'({DatenGespeichert, DatenGeladen, BefehlGeladen}),
                  expPulse);
      checkOutput("BefehlDaten", BefehlDaten, befehlModel);
      checkOutput("LeseDaten", LeseDaten, leseModel);

      strobeVec = {SpeicherSchreiben, SpeicherLesen};
      if (expectLow) begin
        checkOutput("strobe after ready", 32'(strobeVec), 32'h0);
        expectLow = 1'b0;
      end
      if (memBusy) begin
        checkOutput("strobe held", 32'(strobeVec), 32'(expStrobe(cur.kind)));
        checkOutput("address held", SpeicherAdresse, cur.addr);
        if (cur.kind == K_STORE)
          checkOutput("wdata held", SpeicherSchreibDaten, cur.wdata);
      end else if (strobeVec != 2'b00) begin
        if (accQ.size() == 0) begin
          checkOutput("unexpected grant", 32'(strobeVec), 32'h0);
        end else begin
          e = accQ.pop_front();
          cur = e;
          checkOutput("grant strobe", 32'(strobeVec), 32'(expStrobe(cur.kind)));
          checkOutput("grant cycle", 32'(cycle), 32'(cur.due));
          checkOutput("grant address", SpeicherAdresse, cur.addr);
          if (cur.kind == K_STORE)
            checkOutput("grant wdata", SpeicherSchreibDaten, cur.wdata);
          memBusy = 1'b1;
          waitCnt = 0;
          latency = (forceLatency >= 0) ? forceLatency : $urandom_range(0, 4);
          rdData  = useForceData ? forceData : $urandom;
        end
      end else begin
        if (accQ.size() > 0 && !accQ[0].chained && accQ[0].due <= cycle) begin
          e = accQ.pop_front();
          checkOutput("missed grant cycle", 32'(cycle), 32'(e.due));
        end
        SpeicherBereit    = 1'($urandom_range(0, 1));
        SpeicherLeseDaten = $urandom;
      end

      if (memBusy) begin
        if (waitCnt == latency) begin
          SpeicherBereit    = 1'b1;
          SpeicherLeseDaten = (cur.kind == K_STORE) ? $urandom : rdData;
          c.kind = cur.kind;
          c.data = rdData;
          c.due  = cycle + 1;
          compQ.push_back(c);
          memBusy   = 1'b0;
          expectLow = 1'b1;
        end else begin
          SpeicherBereit    = 1'b0;
          SpeicherLeseDaten = $urandom;
          waitCnt++;
        end
      end
    end
  end

  // Issues a request set from a known-idle arbiter and predicts the grant
  // order: store, then load, then fetch (plus holdFetch re-grants of a
  // fetch level that is kept high). Only the first grant has a fixed
  // cycle; each later one follows two cycles after the previous pulse.
  task automatic applyStimulus(input bit st, input bit ld, input bit fe,
                               input int holdFetch, input logic [31:0] bAdr,
                               input logic [31:0] dAdr,
                               input logic [31:0] wData);
    accessT e;
    bit first = 1'b1;
    e.due = cycle + 1;
    if (st) begin
      e.kind = K_STORE; e.addr = dAdr; e.wdata = wData; e.chained = !first;
      accQ.push_back(e); first = 1'b0;
    end
    if (ld) begin
      e.kind = K_LOAD; e.addr = dAdr; e.wdata = '0; e.chained = !first;
      accQ.push_back(e); first = 1'b0;
    end
    if (fe) begin
      for (int i = 0; i <= holdFetch; i++) begin
        e.kind = K_FETCH; e.addr = bAdr; e.wdata = '0; e.chained = !first;
        accQ.push_back(e); first = 1'b0;
      end
    end
    BefehlAdresse   = bAdr;
    DatenAdresse    = dAdr;
    SchreibDaten    = wData;
    holdCount       = holdFetch;
    SpeicherAnfrage = st;
    LadeAnfrage     = ld;
    BefehlAnfrage   = fe;
  endtask

  task automatic waitQuiet(input int budget);
    int  n = 0;
    bit  done;
    do begin
      @(negedge Clock); #1;
      n++;
      done = accQ.size() == 0 && compQ.size() == 0 && !memBusy &&
             !SpeicherAnfrage && !LadeAnfrage && !BefehlAnfrage;
    end while (!done && n < budget);
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: transaction not finished after %0d cycles, expected completion",
               budget);
      finishRun();
    end
    @(negedge Clock); #1;
  endtask

  initial begin
    repeat (3) @(posedge Clock);
    @(negedge Clock); #1;
    Reset = 1'b0;
    waitQuiet(20);

    $display("[TB] zero-wait fetch");
    forceLatency = 0; useForceData = 1'b1; forceData = 32'hDEADBEEF;
    applyStimulus(0, 0, 1, 0, 32'h40, 32'h0, 32'h0);
    waitQuiet(50);

    $display("[TB] wait-state load");
    forceLatency = 5; forceData = 32'hCAFEF00D;
    applyStimulus(0, 1, 0, 0, 32'h0, 32'h100, 32'h0);
    waitQuiet(50);

    $display("[TB] priority store > load > fetch");
    forceLatency = -1; useForceData = 1'b0;
    applyStimulus(1, 1, 1, 0, 32'h80, 32'h200, 32'h12345678);
    waitQuiet(100);

    $display("[TB] held fetch request");
    applyStimulus(0, 0, 1, 1, 32'h44, 32'h0, 32'h0);
    waitQuiet(100);

    $display("[TB] reset mid-access");
    forceLatency = 20;
    applyStimulus(0, 1, 0, 0, 32'h0, 32'h300, 32'h0);
    repeat (3) begin @(negedge Clock); #1; end
    Reset = 1'b1;
    LadeAnfrage = 1'b0;
    @(negedge Clock); #1;
    Reset = 1'b0;
    repeat (4) begin @(negedge Clock); #1; end
    waitQuiet(50);

    $display("[TB] address change after grant");
    forceLatency = 3;
    applyStimulus(0, 0, 1, 0, 32'h40, 32'h0, 32'h0);
    repeat (2) begin @(negedge Clock); #1; end
    BefehlAdresse = 32'h44;
    waitQuiet(50);

    $display("[TB] random traffic");
    forceLatency = -1;
    for (int i = 0; i < 80; i++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(1, 7));
      applyStimulus(mask[2], mask[1], mask[0], $urandom_range(0, 3) == 0 ? 1 : 0,
                    $urandom, $urandom, $urandom);
      waitQuiet(200);
      repeat ($urandom_range(0, 2)) begin @(negedge Clock); #1; end
    end

    finishRun();
  end

endmodule
